// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg -- elastic EX->MEM pipeline register for the MIPS32 core.
//
// Holds up to two in-flight instructions: the main entry drives the MEM-side
// outputs, and the skid entry absorbs one extra instruction when MEM stalls.
// in_ready comes only from registered state, so MEM back-pressure never forms
// a combinational path back into EX. Payload outputs read as zero whenever no
// entry is valid, which makes an empty slot a harmless bubble.
//
// Optional feature macro: EXMEM_HILO_EN
//   defined   -> hi/lo/hilo_write ports exist and travel with the payload
//   undefined -> those ports and their storage are absent
//
// Priority of controls: rst > flush > valid/ready handshake.

module ex_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int MOP_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    // EX side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_write_i,
    input  logic [MOP_W-1:0]  mem_op_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
`ifdef EXMEM_HILO_EN
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              hilo_write_i,
`endif

    // MEM side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] wdata_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_write_o,
    output logic [MOP_W-1:0]  mem_op_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o
`ifdef EXMEM_HILO_EN
    ,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              hilo_write_o
`endif
);

    // ------------------------------------------------------------------
    // Types
    // ------------------------------------------------------------------

    // Everything that travels from EX to MEM, copied verbatim.
    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] rd_addr;
        logic              rd_write;
        logic [MOP_W-1:0]  mem_op;
        logic [DATA_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_wdata;
`ifdef EXMEM_HILO_EN
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              hilo_write;
`endif
    } payload_t;

    // State bits are {skid_valid, main_valid}; 2'b10 cannot occur because
    // the skid entry only fills while the main entry is occupied.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------

    state_t   state_q, state_d;
    payload_t main_q,  main_d;
    payload_t skid_q,  skid_d;
    payload_t in_pl;
    payload_t out_pl;

    logic main_valid;
    logic skid_valid;
    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // Input packing and handshake terms
    // ------------------------------------------------------------------

    assign in_pl.wdata      = wdata_i;
    assign in_pl.rd_addr    = rd_addr_i;
    assign in_pl.rd_write   = rd_write_i;
    assign in_pl.mem_op     = mem_op_i;
    assign in_pl.mem_addr   = mem_addr_i;
    assign in_pl.mem_wdata  = mem_wdata_i;
`ifdef EXMEM_HILO_EN
    assign in_pl.hi         = hi_i;
    assign in_pl.lo         = lo_i;
    assign in_pl.hilo_write = hilo_write_i;
`endif

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];

    // Ready only while the skid slot is free: one cycle of MEM stall can
    // always be absorbed without looking at out_ready.
    assign in_ready  = !rst && !skid_valid;
    assign out_valid = main_valid;

    assign push = in_valid && in_ready;
    assign pop  = main_valid && out_ready;

    // ------------------------------------------------------------------
    // Control state register
    // ------------------------------------------------------------------

    // Register the occupancy state; synchronous reset empties both entries.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Register the payload entries; their contents only matter while the
    // matching state bit says they are valid.
    always_ff @(posedge clk) begin
        // NOTE: payload storage has no reset on purpose; validity lives in
        // state_q and the output mux zeroes anything not marked valid.
        main_q <= main_d;
        skid_q <= skid_d;
    end

    // ------------------------------------------------------------------
    // Next-state and payload movement
    // ------------------------------------------------------------------

    // Decide where the incoming and held payloads go this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    main_d  = in_pl;
                    state_d = ST_ONE;
                end
            end

            ST_ONE: begin
                if (push && pop) begin
                    main_d  = in_pl;
                    state_d = ST_ONE;
                end else if (push) begin
                    skid_d  = in_pl;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end

            ST_FULL: begin
                // in_ready is low here, so only a pop can move things.
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end

            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // A flush kills both entries and discards any same-cycle push.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    // ------------------------------------------------------------------
    // Output bubble gating
    // ------------------------------------------------------------------

    assign out_pl = main_valid ? main_q : '0;

    assign wdata_o      = out_pl.wdata;
    assign rd_addr_o    = out_pl.rd_addr;
    assign rd_write_o   = out_pl.rd_write;
    assign mem_op_o     = out_pl.mem_op;
    assign mem_addr_o   = out_pl.mem_addr;
    assign mem_wdata_o  = out_pl.mem_wdata;
`ifdef EXMEM_HILO_EN
    assign hi_o         = out_pl.hi;
    assign lo_o         = out_pl.lo;
    assign hilo_write_o = out_pl.hilo_write;
`endif

    // ------------------------------------------------------------------
    // Structural properties
    // ------------------------------------------------------------------

    // The skid slot never holds data while the main slot is empty.
    a_legal_state: assert property (@(posedge clk) disable iff (rst)
        state_q != state_t'(2'b10));

    // A stalled output must stay put until MEM takes it.
    a_hold_on_stall: assert property (@(posedge clk) disable iff (rst || flush)
        (out_valid && !out_ready) |=> (out_valid && out_pl == $past(out_pl)));

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: reset, streaming, back-pressure, flush,
// bubble and reset-mid-burst. Table rows give the inputs for one clock and
// the outputs expected just after that edge; payload fields are derived from
// a small tag so every row is a single hand-checked line.

module tb_ex_mem_skid_reg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int MOP_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] wdata_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_write_i;
    logic [MOP_W-1:0]  mem_op_i;
    logic [DATA_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] wdata_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic              rd_write_o;
    logic [MOP_W-1:0]  mem_op_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
`ifdef EXMEM_HILO_EN
    logic [DATA_W-1:0] hi_i, lo_i, hi_o, lo_o;
    logic              hilo_write_i, hilo_write_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_mem_skid_reg #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .MOP_W (MOP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wdata_i     (wdata_i),
        .rd_addr_i   (rd_addr_i),
        .rd_write_i  (rd_write_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
`ifdef EXMEM_HILO_EN
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .hilo_write_i(hilo_write_i),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .wdata_o     (wdata_o),
        .rd_addr_o   (rd_addr_o),
        .rd_write_o  (rd_write_o),
        .mem_op_o    (mem_op_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o)
`ifdef EXMEM_HILO_EN
        ,
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .hilo_write_o(hilo_write_o)
`endif
    );

    // One vector: inputs for a cycle and the outputs expected after its edge.
    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic [7:0] tag;
        logic       e_ov;
        logic       e_irdy;
        logic [7:0] e_tag;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [7:0] tag,
                                logic e_ov, logic e_irdy, logic [7:0] e_tag);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.tag = tag;
        v.e_ov = e_ov; v.e_irdy = e_irdy; v.e_tag = e_tag;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Payload encoding for a tag: wdata = 0x0F + tag, rd = tag, rd_write = 1,
    // mem_op = tag[3:0], mem_addr = 0x1000 + tag, mem_wdata = 0xA5000000 | tag.
    task automatic drive_tag(input logic [7:0] tag);
        wdata_i     = 32'h0000_000F + {24'h0, tag};
        rd_addr_i   = tag[4:0];
        rd_write_i  = 1'b1;
        mem_op_i    = tag[3:0];
        mem_addr_i  = 32'h0000_1000 + {24'h0, tag};
        mem_wdata_i = 32'hA500_0000 | {24'h0, tag};
`ifdef EXMEM_HILO_EN
        hi_i = '0; lo_i = '0; hilo_write_i = 1'b0;
`endif
    endtask

    // Compare every payload output with the tag encoding, or with zero when
    // no entry is expected to be valid.
    task automatic check_payload(input string pfx, input logic valid, input logic [7:0] tag);
        logic [7:0] t;
        t = tag;
        if (valid) begin
            check({pfx, ".wdata_o"},     wdata_o,            32'h0000_000F + {24'h0, t});
            check({pfx, ".rd_addr_o"},   {27'h0, rd_addr_o}, {27'h0, t[4:0]});
            check({pfx, ".rd_write_o"},  {31'h0, rd_write_o}, 32'd1);
            check({pfx, ".mem_op_o"},    {28'h0, mem_op_o},  {28'h0, t[3:0]});
            check({pfx, ".mem_addr_o"},  mem_addr_o,         32'h0000_1000 + {24'h0, t});
            check({pfx, ".mem_wdata_o"}, mem_wdata_o,        32'hA500_0000 | {24'h0, t});
        end else begin
            check({pfx, ".wdata_o"},     wdata_o,            32'd0);
            check({pfx, ".rd_addr_o"},   {27'h0, rd_addr_o}, 32'd0);
            check({pfx, ".rd_write_o"},  {31'h0, rd_write_o}, 32'd0);
            check({pfx, ".mem_op_o"},    {28'h0, mem_op_o},  32'd0);
            check({pfx, ".mem_addr_o"},  mem_addr_o,         32'd0);
            check({pfx, ".mem_wdata_o"}, mem_wdata_o,        32'd0);
        end
    endtask

    initial begin
        // Streaming: tags 1..8 -> wdata 0x10..0x17, one per cycle.
        for (int i = 0; i < 8; i++)
            vecs[i] = mk(1, 1, 0, 8'(i + 1), 1, 1, 8'(i + 1));
        vecs[8]  = mk(0, 1, 0, 8'h00, 0, 1, 8'h00);  // drain -> empty
        // Back-pressure: A held, B to skid, C refused, then released in order.
        vecs[9]  = mk(1, 0, 0, 8'h0A, 1, 1, 8'h0A);
        vecs[10] = mk(1, 0, 0, 8'h0B, 1, 0, 8'h0A);
        vecs[11] = mk(1, 0, 0, 8'h0C, 1, 0, 8'h0A);
        vecs[12] = mk(1, 1, 0, 8'h0C, 1, 1, 8'h0B);  // pop: skid -> main
        vecs[13] = mk(1, 1, 0, 8'h0C, 1, 1, 8'h0C);  // C re-presented
        vecs[14] = mk(0, 1, 0, 8'h00, 0, 1, 8'h00);
        // ONE with neither push nor pop holds.
        vecs[15] = mk(1, 0, 0, 8'h0D, 1, 1, 8'h0D);
        vecs[16] = mk(0, 0, 0, 8'h00, 1, 1, 8'h0D);
        vecs[17] = mk(0, 1, 0, 8'h00, 0, 1, 8'h00);
        // Flush while FULL with C presented: everything gone.
        vecs[18] = mk(1, 0, 0, 8'h0E, 1, 1, 8'h0E);
        vecs[19] = mk(1, 0, 0, 8'h0F, 1, 0, 8'h0E);
        vecs[20] = mk(1, 0, 1, 8'h10, 0, 1, 8'h00);
        // Flush in ONE with a real push: the push is discarded too.
        vecs[21] = mk(1, 0, 0, 8'h11, 1, 1, 8'h11);
        vecs[22] = mk(1, 0, 1, 8'h12, 0, 1, 8'h00);
        vecs[23] = mk(0, 1, 0, 8'h00, 0, 1, 8'h00);

        // ---------------- Reset with in_valid held high ----------------
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        drive_tag(8'h3F);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("rst%0d.out_valid", c), {31'h0, out_valid}, 32'd0);
            check($sformatf("rst%0d.in_ready", c),  {31'h0, in_ready},  32'd0);
            check_payload($sformatf("rst%0d", c), 1'b0, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("post_rst.in_ready", {31'h0, in_ready}, 32'd1);

        // ---------------- Table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            drive_tag(vecs[i].tag);
            @(posedge clk); #1;
            check($sformatf("vec%0d.out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].e_ov});
            check($sformatf("vec%0d.in_ready", i),  {31'h0, in_ready},  {31'h0, vecs[i].e_irdy});
            check_payload($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_tag);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;

        // ---------------- Bubble after a store ----------------
        in_valid = 1'b1; out_ready = 1'b1;
        wdata_i = 32'h0000_0100; rd_addr_i = '0; rd_write_i = 1'b0;
        mem_op_i = 4'd2; mem_addr_i = 32'h0000_0100; mem_wdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("store.out_valid",   {31'h0, out_valid}, 32'd1);
        check("store.mem_op_o",    {28'h0, mem_op_o},  32'd2);
        check("store.mem_addr_o",  mem_addr_o,         32'h0000_0100);
        check("store.mem_wdata_o", mem_wdata_o,        32'hDEAD_BEEF);
        check("store.rd_write_o",  {31'h0, rd_write_o}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bubble.out_valid",   {31'h0, out_valid}, 32'd0);
        check("bubble.mem_op_o",    {28'h0, mem_op_o},  32'd0);
        check("bubble.rd_write_o",  {31'h0, rd_write_o}, 32'd0);
        check("bubble.mem_addr_o",  mem_addr_o,         32'd0);
        check("bubble.mem_wdata_o", mem_wdata_o,        32'd0);

        // ---------------- Reset mid-burst (FULL) ----------------
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; drive_tag(8'h13);
        @(negedge clk);
        drive_tag(8'h14);
        @(negedge clk);
        check("prerst.in_ready", {31'h0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_comb.in_ready", {31'h0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("midrst.out_valid", {31'h0, out_valid}, 32'd0);
        check_payload("midrst", 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("midrst_rel.in_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("midrst_after.out_valid", {31'h0, out_valid}, 32'd0);

`ifdef EXMEM_HILO_EN
        // ---------------- HI/LO through the FULL -> ONE path ----------------
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        drive_tag(8'h04);
        @(negedge clk);
        drive_tag(8'h05);
        hi_i = 32'h1; lo_i = 32'h2; hilo_write_i = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("hilo.rd_addr_o",    {27'h0, rd_addr_o},    32'd5);
        check("hilo.hi_o",         hi_o,                  32'h1);
        check("hilo.lo_o",         lo_o,                  32'h2);
        check("hilo.hilo_write_o", {31'h0, hilo_write_o}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hilo_bubble.hi_o", hi_o, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
